// File: rtl/bitreverse_stream_ctrl_if.sv
// Valid/ready sample stream with an end-of-stream marker.
interface bitreverse_stream_ctrl_if #(
    parameter int DW = 48
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/bitreverse_stream_ctrl.sv
// Stream sequencer for a clock-enabled bit-reverse stage: generates ce/reset,
// drops the unprimed first frame, flushes the tail with zeros, marks last.
module bitreverse_stream_ctrl #(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    bitreverse_stream_ctrl_if.slave  s,
    bitreverse_stream_ctrl_if.master m,
    output logic                    o_ce,
    output logic                    o_dp_reset,
    output logic [2*WIDTH-1:0]      o_dp_in,
    input  logic [2*WIDTH-1:0]      i_dp_out,
    input  logic                    i_dp_sync,
    output logic                    o_busy
);
    localparam int N = 1 << LGSIZE;
    localparam logic [LGSIZE-1:0] LAST_IDX = LGSIZE'(N - 1);
    localparam logic [LGSIZE:0] FLUSH_LEN = (LGSIZE + 1)'(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t            state;
    logic [LGSIZE-1:0] in_cnt;
    logic [LGSIZE:0]   flush_cnt;
    logic              r_pend;
    logic              primed;
    logic              dp_rst_q;
    logic              adv;
    logic              ingest;
    logic              end_hs;

    assign m.valid = r_pend && (primed || i_dp_sync);
    assign m.data  = i_dp_out;
    assign m.last  = m.valid && (state == FLUSH) && (flush_cnt == FLUSH_LEN);

    assign adv        = !m.valid || m.ready;
    assign o_dp_reset = i_reset || dp_rst_q;
    assign end_hs     = m.valid && m.ready && m.last;

    // No samples are taken while the stage is held in reset.
    assign ingest  = (state != FLUSH) && !o_dp_reset;
    assign s.ready = ingest && adv;
    assign o_busy  = (state != IDLE);
    assign o_dp_in = (state == FLUSH) ? '0 : s.data;

    always_comb begin
        o_ce = 1'b0;
        if (ingest)
            o_ce = s.valid && adv;
        else if ((state == FLUSH) && !o_dp_reset)
            o_ce = (flush_cnt < FLUSH_LEN) && adv;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            in_cnt    <= '0;
            flush_cnt <= '0;
            r_pend    <= 1'b0;
            primed    <= 1'b0;
            dp_rst_q  <= 1'b1;
        end else begin
            dp_rst_q <= 1'b0;
            if (o_ce)
                r_pend <= 1'b1;
            else if (m.ready)
                r_pend <= 1'b0;
            if (r_pend && i_dp_sync)
                primed <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (o_ce) begin
                        state  <= RUN;
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (o_ce) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (s.last && (in_cnt == LAST_IDX)) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (o_ce)
                        flush_cnt <= flush_cnt + 1'b1;
                    // Last beat taken: restart the stage so it re-primes.
                    if (end_hs) begin
                        state    <= IDLE;
                        in_cnt   <= '0;
                        primed   <= 1'b0;
                        r_pend   <= 1'b0;
                        dp_rst_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitreverse_stream_ctrl.sv
// Bench for bitreverse_stream_ctrl with a behavioural bit-reverse stage and
// a frame-reordering scoreboard.
module tb_bitreverse_stream_ctrl;
    localparam int LG = 5;
    localparam int N  = 1 << LG;
    localparam int W  = 24;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;
    logic o_ce;
    logic o_dp_reset;
    logic o_busy;
    logic [2*W-1:0] o_dp_in;
    logic [2*W-1:0] dp_out  = '0;
    logic           dp_sync = 1'b0;

    bitreverse_stream_ctrl_if #(.DW(2*W)) s_if ();
    bitreverse_stream_ctrl_if #(.DW(2*W)) m_if ();

    bitreverse_stream_ctrl #(.LGSIZE(LG), .WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .s          (s_if),
        .m          (m_if),
        .o_ce       (o_ce),
        .o_dp_reset (o_dp_reset),
        .o_dp_in    (o_dp_in),
        .i_dp_out   (dp_out),
        .i_dp_sync  (dp_sync),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LG; b++)
            if (v[b]) r = r | (1 << (LG - 1 - b));
        return r;
    endfunction

    function automatic logic [2*W-1:0] mk(input int tag, input int idx);
        return {8'(tag), 16'(idx), 24'(idx * 7 + tag + 1)};
    endfunction

    // Bit-reverse stage: double-buffered, one-cycle output register,
    // sync withheld for the first frame after reset.
    logic [2*W-1:0] st_mem [0:2*N-1];
    int st_cnt = 0;
    always @(posedge i_clk) begin
        if (o_dp_reset) begin
            st_cnt  <= 0;
            dp_out  <= '0;
            dp_sync <= 1'b0;
        end else if (o_ce) begin
            st_mem[st_cnt % (2*N)] <= o_dp_in;
            dp_out  <= st_mem[((st_cnt / N + 1) % 2) * N + bitrev(st_cnt % N)];
            dp_sync <= (st_cnt % N == 0) && (st_cnt >= N);
            st_cnt  <= st_cnt + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    logic [2*W-1:0] in_q[$];
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held;
    bit rst_prev   = 0;
    bit flush_exp  = 0;
    bit first_seen = 0;
    bit stalled    = 0;
    bit exp_last;
    int acc_idx    = 0;
    int out_k      = 0;
    int ce_since   = 0;
    int flush_ces  = 0;
    int post_last  = 0;
    int pin;

    always @(negedge i_clk) begin
        if (i_reset) begin
            rst_prev   = 1;
            in_q.delete();
            exp_q.delete();
            flush_exp  = 0;
            first_seen = 0;
            stalled    = 0;
            acc_idx    = 0;
            out_k      = 0;
            ce_since   = 0;
            flush_ces  = 0;
            post_last  = 0;
        end else begin
            if (rst_prev) begin
                chk("rst_m_valid", 64'(m_if.valid), 0);
                chk("rst_m_last", 64'(m_if.last), 0);
                chk("rst_busy", 64'(o_busy), 0);
                chk("rst_dp_reset", 64'(o_dp_reset), 1);
                rst_prev = 0;
            end
            if (post_last == 1) begin
                chk("end_pulse_hi", 64'(o_dp_reset), 1);
                chk("end_busy", 64'(o_busy), 0);
                post_last = 2;
            end else if (post_last == 2) begin
                chk("end_pulse_lo", 64'(o_dp_reset), 0);
                post_last = 0;
            end
            if (o_dp_reset) begin
                chk("dp_reset_quiet", 64'({o_ce, s_if.ready}), 0);
                ce_since   = 0;
                first_seen = 0;
            end
            if (stalled)
                chk("stall_hold", 64'({m_if.valid, m_if.data}), 64'({1'b1, held}));
            if (m_if.valid && !first_seen) begin
                chk("first_out_ce", 64'(ce_since), 64'(N + 1));
                first_seen = 1;
            end
            if (m_if.valid && m_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(m_if.valid), 0);
                end else begin
                    exp_last = flush_exp && (exp_q.size() == 1);
                    chk("out_data", 64'(m_if.data), 64'(exp_q.pop_front()));
                    chk("out_last", 64'(m_if.last), 64'(exp_last));
                    pin = -1;
                    case (out_k)
                        0:  pin = 0;
                        1:  pin = 16;
                        2:  pin = 8;
                        31: pin = 31;
                        32: pin = 32;
                        33: pin = 48;
                        default: pin = -1;
                    endcase
                    if (pin >= 0)
                        chk("pin_idx", 64'(m_if.data[39:24]), 64'(pin));
                    out_k++;
                    if (m_if.last) begin
                        chk("flush_ce_count", 64'(flush_ces), 64'(N));
                        post_last = 1;
                        flush_exp = 0;
                        acc_idx   = 0;
                        out_k     = 0;
                    end
                end
            end
            if (flush_exp)
                chk("flush_s_ready", 64'(s_if.ready), 0);
            else if (!o_dp_reset && !m_if.valid)
                chk("run_s_ready", 64'(s_if.ready), 1);
            if (o_ce) begin
                chk("ce_adv", 64'(!m_if.valid || m_if.ready), 1);
                if (flush_exp) begin
                    chk("flush_zero", 64'(o_dp_in), 0);
                    flush_ces++;
                end else begin
                    chk("ce_has_sample", 64'(s_if.valid && s_if.ready), 1);
                end
            end
            if (s_if.valid && s_if.ready) begin
                chk("accept_ce", 64'({o_ce, o_dp_in}), 64'({1'b1, s_if.data}));
                in_q.push_back(s_if.data);
                if (acc_idx == N - 1 && s_if.last) begin
                    flush_exp = 1;
                    flush_ces = 0;
                end
                acc_idx = (acc_idx + 1) % N;
                if (in_q.size() == N) begin
                    for (int k = 0; k < N; k++)
                        exp_q.push_back(in_q[bitrev(k)]);
                    in_q.delete();
                end
            end
            if (o_ce) ce_since++;
            stalled = m_if.valid && !m_if.ready;
            held    = m_if.data;
        end
    end

    int cyc      = 0;
    int rdy_mode = 0;

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (rdy_mode == 1) m_if.ready = ~m_if.ready;
        else m_if.ready = 1'b1;
    endtask

    task automatic send_stream(input int tag, input int nframes, input int gap,
                               input int bad_idx, input int abort_at);
        int  idx;
        int  guard;
        bit  hold;
        int  total;
        idx   = 0;
        guard = 0;
        hold  = 0;
        total = nframes * N;
        while (idx < total) begin
            if (!hold) s_if.valid = (cyc % gap) == 0;
            s_if.data = mk(tag, idx);
            s_if.last = (idx == total - 1) || (idx == bad_idx);
            @(negedge i_clk);
            if (s_if.valid && s_if.ready) begin
                idx++;
                hold = 0;
            end else begin
                hold = s_if.valid;
            end
            tick();
            if (idx == abort_at) break;
            guard++;
            if (guard > 4000) begin
                $display("FAIL send_timeout tag=%0d idx=%0d", tag, idx);
                $fatal(1, "input stream stuck");
            end
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic wait_idle(input int extra);
        bit done;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge i_clk);
            done = !o_busy && (exp_q.size() == 0);
            tick();
        end
        if (!done) begin
            $display("FAIL idle_timeout busy=%0d pending=%0d", o_busy, exp_q.size());
            $fatal(1, "stream never ended");
        end
        repeat (extra) tick();
    endtask

    initial begin
        s_if.valid  = 1'b0;
        s_if.last   = 1'b0;
        s_if.data   = '0;
        m_if.ready  = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        repeat (2) tick();

        send_stream(1, 2, 1, -1, -1);
        wait_idle(3);

        rdy_mode = 1;
        send_stream(2, 2, 1, -1, -1);
        wait_idle(3);
        rdy_mode = 0;

        send_stream(3, 2, 1, 10, -1);
        wait_idle(0);
        send_stream(4, 2, 1, -1, -1);
        wait_idle(3);

        send_stream(5, 2, 1, -1, N + 17);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        repeat (3) tick();
        send_stream(6, 2, 1, -1, -1);
        wait_idle(3);

        send_stream(7, 2, 3, -1, -1);
        wait_idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
